// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative 32-bit restoring divider that owns the MIPS HI/LO
// registers. div/divu start it. mthi/mtlo write HI/LO directly while it is idle.
// Any HI/LO access made while a division is in flight raises a combinational
// stall until the result has landed.
//
// Optional feature macro: HILO_DIV_EARLY_OUT_EN. When it is defined, divisions
// with |dividend| < |divisor|, and divisions by zero, finish after 2 busy cycles
// instead of 33.
//
// Handshake: start is a single-cycle request with no ready. A start that
// arrives while busy aborts the division in flight and restarts with the new
// operands. done is a single-cycle pulse in the cycle where HI/LO first show
// the new result. busy stays high from the cycle after start up to and
// including the fix-up cycle.
module hilo_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [4:0]  cnt_q;
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] quo_q;      // holds |dividend| at first, then shifts in quotient bits
  logic [32:0] dvsr_q;     // |divisor|, held 33 bits wide to match the trial compare
  logic        neg_q_q;    // quotient must be negated at fix-up
  logic        neg_r_q;    // remainder must be negated at fix-up
  logic        dvz_q;      // divide by zero: override the result
  logic [31:0] dvd_q;      // original dividend, returned in HI on divide by zero
  logic        early_hit;  // skip the iterations and go straight to fix-up

  // Operand magnitudes. They are unsigned, so |0x80000000| = 0x80000000 exactly.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // One restoring step: shift {rem, quo} left by one and trial-subtract.
  logic [32:0] rem_sh;
  logic        trial_ge;
  logic [31:0] rem_sub;

  // Operand sign detection and magnitude for the values sampled with start.
  always_comb begin
    a_neg = is_signed & dividend[31];
    b_neg = is_signed & divisor[31];
    a_mag = a_neg ? (32'd0 - dividend) : dividend;
    b_mag = b_neg ? (32'd0 - divisor) : divisor;
  end

  // Trial subtraction for the current iteration. When trial_ge is set the true
  // difference is below 2^32, so the low 32 bits of the subtraction are exact.
  always_comb begin
    rem_sh   = {rem_q, quo_q[31]};
    trial_ge = (rem_sh >= dvsr_q);
    rem_sub  = rem_sh[31:0] - dvsr_q[31:0];
  end

`ifdef HILO_DIV_EARLY_OUT_EN
  logic early_q;

  // Latch the early-out decision at start. A later start replaces it.
  always_ff @(posedge clk) begin
    if (rst) begin
      early_q <= 1'b0;
    end else if (start) begin
      early_q <= (a_mag < b_mag) || (divisor == 32'd0);
    end
  end

  assign early_hit = early_q;
`else
  assign early_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start always (re)launches a division.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (early_hit || (cnt_q == 5'd31)) state_d = FIX;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, iteration, fix-up and the architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 33'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dvz_q   <= 1'b0;
      dvd_q   <= 32'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        dvz_q   <= (divisor == 32'd0);
        dvd_q   <= dividend;
        quo_q   <= a_mag;
        rem_q   <= 32'd0;
        dvsr_q  <= {1'b0, b_mag};
        cnt_q   <= 5'd0;
      end else begin
        case (state_q)
          RUN: begin
            if (early_hit) begin
              // The quotient is 0 and the remainder is the whole dividend magnitude.
              rem_q <= quo_q;
              quo_q <= 32'd0;
            end else begin
              rem_q <= trial_ge ? rem_sub : rem_sh[31:0];
              quo_q <= {quo_q[30:0], trial_ge};
              cnt_q <= cnt_q + 5'd1;
            end
          end
          FIX: begin
            if (dvz_q) begin
              lo <= 32'hFFFF_FFFF;
              hi <= dvd_q;
            end else begin
              lo <= neg_q_q ? (32'd0 - quo_q) : quo_q;
              hi <= neg_r_q ? (32'd0 - rem_q) : rem_q;
            end
            done <= 1'b1;
          end
          default: ;
        endcase
      end
      // mthi/mtlo take effect only while idle. While busy they are held off by stall.
      if (state_q == IDLE) begin
        if (hi_wr) hi <= wr_data;
        if (lo_wr) lo <= wr_data;
      end
    end
  end

  // Status outputs. stall is combinational so the pipeline holds in the same cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    stall     = busy & (rd_hi | rd_lo | hi_wr | lo_wr);
    dbg_state = state_q;
  end

endmodule
